// File: rtl/gfx_rom_responder.sv
// gfx_rom_responder
//   Serves 32-bit graphics-ROM fetches from one tile/sprite layer. Each
//   request word address is queued, turned into a two-beat 16-bit SDRAM
//   burst, and the two beats are assembled into one 32-bit reply that is
//   announced with a single-cycle sdr_rdy pulse. Replies come back strictly
//   in request order.
//
//   Optional feature (macro GFX_ROM_CACHE_EN): a 1-entry tag register holds
//   the last completed address/data pair; a popped address matching a valid
//   tag is answered without touching memory.
//
// Ports
//   CLK_32M    in   1   system clock
//   RESET      in   1   synchronous, active-high reset
//   sdr_req    in   1   one-cycle request strobe from the layer
//   sdr_addr   in  20   32-bit word address, sampled with sdr_req
//   sdr_data   out 32   returned ROM word, held until the next sdr_rdy
//   sdr_rdy    out  1   one-cycle pulse, sdr_data valid this cycle
//   mem_addr   out 25   SDRAM byte address of the burst
//   mem_req    out  1   burst request, held high until mem_ack
//   mem_ack    in   1   controller accepted the burst
//   mem_valid  in   1   16-bit beat valid
//   mem_dout   in  16   beat data
//   overflow   out  1   sticky: a request was dropped on a full queue
//   dbg_state_o out 3   current FSM state (IDLE=0 ISSUE=1 BEAT0=2 BEAT1=3 RESP=4)
//
// Handshake: the layer side has no back-pressure; sdr_req is a strobe that
// is either queued or dropped (setting overflow). On the memory side,
// mem_req/mem_addr stay stable until mem_ack is seen; beats are taken on
// mem_valid only while a burst is outstanding (BEAT0/BEAT1, or ISSUE when
// mem_valid coincides with mem_ack).

module gfx_rom_responder #(
  parameter logic [24:0] BASE_ADDR   = 25'h0100000,
  parameter int          QDEPTH_LOG2 = 1            // must be >= 1
) (
  input  logic        CLK_32M,
  input  logic        RESET,
  input  logic        sdr_req,
  input  logic [19:0] sdr_addr,
  output logic [31:0] sdr_data,
  output logic        sdr_rdy,
  output logic [24:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic        mem_valid,
  input  logic [15:0] mem_dout,
  output logic        overflow,
  output logic [2:0]  dbg_state_o
);

  localparam int QDEPTH = 1 << QDEPTH_LOG2;

  localparam logic [QDEPTH_LOG2-1:0] PTR_ONE  = QDEPTH_LOG2'(1);
  localparam logic [QDEPTH_LOG2:0]   CNT_ONE  = (QDEPTH_LOG2 + 1)'(1);
  localparam logic [QDEPTH_LOG2:0]   CNT_FULL = (QDEPTH_LOG2 + 1)'(QDEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_BEAT0 = 3'd2,
    S_BEAT1 = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                 state_q;
  logic [31:0]            sdr_data_q;
  logic                   sdr_rdy_q;
  logic [24:0]            mem_addr_q;
  logic                   mem_req_q;
  logic                   overflow_q;
  logic [15:0]            data_lo_q;

  // Request queue: circular buffer, count has one extra bit to tell full
  // from empty.
  logic [19:0]            q_mem [QDEPTH];
  logic [QDEPTH_LOG2-1:0] wr_ptr_q;
  logic [QDEPTH_LOG2-1:0] rd_ptr_q;
  logic [QDEPTH_LOG2:0]   count_q;

  logic                   q_empty;
  logic                   q_full;
  logic                   push;
  logic                   pop;
  logic [19:0]            head_addr;
  logic [24:0]            mem_addr_d;

`ifdef GFX_ROM_CACHE_EN
  logic [19:0]            cur_addr_q;   // word address of the burst in flight
  logic [19:0]            tag_addr_q;
  logic [31:0]            tag_data_q;
  logic                   tag_valid_q;
  logic                   hit_q;        // RESP was entered from a tag hit
  logic                   tag_hit;
`endif

  assign q_empty   = (count_q == '0);
  assign q_full    = (count_q == CNT_FULL);
  // A full queue drops the strobe even if the FSM pops in the same cycle.
  assign push      = sdr_req && !q_full;
  assign pop       = (state_q == S_IDLE) && !q_empty;
  assign head_addr = q_mem[rd_ptr_q];
  // Word address to byte address; the 25-bit sum wraps naturally.
  assign mem_addr_d = BASE_ADDR + {3'b000, head_addr, 2'b00};

`ifdef GFX_ROM_CACHE_EN
  assign tag_hit = tag_valid_q && (tag_addr_q == head_addr);
`endif

  // Queue storage needs no reset: only the pointers define its contents.
  always_ff @(posedge CLK_32M) begin
    if (push) begin
      q_mem[wr_ptr_q] <= sdr_addr;
    end
  end

  always_ff @(posedge CLK_32M) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      sdr_data_q  <= '0;
      sdr_rdy_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      overflow_q  <= 1'b0;
      data_lo_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
`ifdef GFX_ROM_CACHE_EN
      cur_addr_q  <= '0;
      tag_addr_q  <= '0;
      tag_data_q  <= '0;
      tag_valid_q <= 1'b0;
      hit_q       <= 1'b0;
`endif
    end else begin
      sdr_rdy_q <= 1'b0;

      if (sdr_req && q_full) begin
        overflow_q <= 1'b1;
      end

      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase

      case (state_q)
        S_IDLE: begin
          if (!q_empty) begin
`ifdef GFX_ROM_CACHE_EN
            cur_addr_q <= head_addr;
            if (tag_hit) begin
              hit_q   <= 1'b1;
              state_q <= S_RESP;
            end else begin
              mem_addr_q <= mem_addr_d;
              mem_req_q  <= 1'b1;
              state_q    <= S_ISSUE;
            end
`else
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= 1'b1;
            state_q    <= S_ISSUE;
`endif
          end
        end

        S_ISSUE: begin
          // Beats before the ack are not ours; a beat arriving with the
          // ack is the first beat of this burst.
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (mem_valid) begin
              data_lo_q <= mem_dout;
              state_q   <= S_BEAT1;
            end else begin
              state_q   <= S_BEAT0;
            end
          end
        end

        S_BEAT0: begin
          if (mem_valid) begin
            data_lo_q <= mem_dout;
            state_q   <= S_BEAT1;
          end
        end

        S_BEAT1: begin
          // The reply is published on the last beat's edge, so sdr_rdy is
          // high during RESP on the memory path.
          if (mem_valid) begin
            sdr_data_q <= {mem_dout, data_lo_q};
            sdr_rdy_q  <= 1'b1;
            state_q    <= S_RESP;
`ifdef GFX_ROM_CACHE_EN
            tag_addr_q  <= cur_addr_q;
            tag_data_q  <= {mem_dout, data_lo_q};
            tag_valid_q <= 1'b1;
`endif
          end
        end

        S_RESP: begin
`ifdef GFX_ROM_CACHE_EN
          // On a hit RESP is the lookup cycle; the reply is published here.
          if (hit_q) begin
            sdr_data_q <= tag_data_q;
            sdr_rdy_q  <= 1'b1;
            hit_q      <= 1'b0;
          end
`endif
          state_q <= S_IDLE;
        end

        default: begin
          state_q   <= S_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign sdr_data    = sdr_data_q;
  assign sdr_rdy     = sdr_rdy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_req     = mem_req_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gfx_rom_responder.sv
module tb_gfx_rom_responder;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;

  always #15 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance (default BASE_ADDR)
  logic        sdr_req = 1'b0;
  logic [19:0] sdr_addr = '0;
  logic [31:0] sdr_data;
  logic        sdr_rdy;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_dout = '0;
  logic        overflow;
  logic [2:0]  dbg_state;

  // second instance with a base close to the top of the address space
  logic        w_req = 1'b0;
  logic [19:0] w_addr = '0;
  logic [31:0] w_data;
  logic        w_rdy;
  logic [24:0] w_mem_addr;
  logic        w_mem_req;
  logic        w_mem_ack = 1'b0;
  logic        w_mem_valid = 1'b0;
  logic [15:0] w_mem_dout = '0;
  logic        w_overflow;
  logic [2:0]  w_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  gfx_rom_responder u_dut (
    .CLK_32M    (clk),
    .RESET      (rst),
    .sdr_req    (sdr_req),
    .sdr_addr   (sdr_addr),
    .sdr_data   (sdr_data),
    .sdr_rdy    (sdr_rdy),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_valid  (mem_valid),
    .mem_dout   (mem_dout),
    .overflow   (overflow),
    .dbg_state_o(dbg_state)
  );

  gfx_rom_responder #(.BASE_ADDR(25'h1FFFFF0)) u_wrap (
    .CLK_32M    (clk),
    .RESET      (rst),
    .sdr_req    (w_req),
    .sdr_addr   (w_addr),
    .sdr_data   (w_data),
    .sdr_rdy    (w_rdy),
    .mem_addr   (w_mem_addr),
    .mem_req    (w_mem_req),
    .mem_ack    (w_mem_ack),
    .mem_valid  (w_mem_valid),
    .mem_dout   (w_mem_dout),
    .overflow   (w_overflow),
    .dbg_state_o(w_dbg_state)
  );

  // ---------------------------------------------------------------- drivers
  // All driving and sampling happens at the falling edge.

  task automatic send_req(input logic [19:0] a, output int t);
    @(negedge clk);
    sdr_addr = a;
    sdr_req  = 1'b1;
    t        = cyc;
    @(negedge clk);
    sdr_req  = 1'b0;
  endtask

  // Controller model: waits for mem_req, optionally stalls the ack (with
  // stray beats when junk=1), then delivers two beats.
  task automatic mem_serve(input int ack_dly, input bit coincide, input bit junk,
                           input logic [15:0] d0, input logic [15:0] d1,
                           output logic [24:0] addr_seen, output bit stable,
                           output logic req_after, output bit ok);
    ok        = 1'b0;
    stable    = 1'b1;
    req_after = 1'bx;
    addr_seen = 'x;
    for (int i = 0; i < 60 && !mem_req; i++) @(negedge clk);
    if (!mem_req) return;
    addr_seen = mem_addr;
    repeat (ack_dly) begin
      if (junk) begin
        mem_valid = 1'b1;
        mem_dout  = 16'hDEAD;
      end
      @(negedge clk);
      if (!mem_req || mem_addr !== addr_seen) stable = 1'b0;
    end
    mem_ack   = 1'b1;
    mem_valid = coincide;
    mem_dout  = coincide ? d0 : 16'h0000;
    @(negedge clk);
    mem_ack   = 1'b0;
    req_after = mem_req;
    if (coincide) begin
      mem_valid = 1'b1;
      mem_dout  = d1;
      @(negedge clk);
      mem_valid = 1'b0;
    end else begin
      mem_valid = 1'b1;
      mem_dout  = d0;
      @(negedge clk);
      mem_dout  = d1;
      @(negedge clk);
      mem_valid = 1'b0;
    end
    ok = 1'b1;
  endtask

  task automatic wait_rdy(output int t, output bit ok);
    ok = 1'b0;
    t  = -1;
    for (int i = 0; i < 60; i++) begin
      if (sdr_rdy) begin
        t  = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (sdr_data !== 32'h0) begin n_errors++; $display("FAIL reset_sdr_data got %h want 0", sdr_data); end
    if (sdr_rdy !== 1'b0)   begin n_errors++; $display("FAIL reset_sdr_rdy got %b want 0", sdr_rdy); end
    if (mem_req !== 1'b0)   begin n_errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    if (mem_addr !== 25'h0) begin n_errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    if (overflow !== 1'b0)  begin n_errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    int t0, t1;
    bit ok, stable;
    logic [24:0] a;
    logic ra;
    send_req(20'h00010, t0);
    mem_serve(0, 1'b0, 1'b0, 16'h1234, 16'hABCD, a, stable, ra, ok);
    n_checks += 3;
    if (!ok) begin n_errors++; $display("FAIL single_mem_req got timeout want mem_req"); end
    if (a !== 25'h0100040) begin n_errors++; $display("FAIL single_mem_addr got %h want 0100040", a); end
    if (ra !== 1'b0) begin n_errors++; $display("FAIL single_req_drop got %b want 0", ra); end
    wait_rdy(t1, ok);
    n_checks += 3;
    if (!ok) begin n_errors++; $display("FAIL single_rdy got timeout want pulse"); end
    if (t1 - t0 != 5) begin n_errors++; $display("FAIL single_latency got %0d want 5", t1 - t0); end
    if (sdr_data !== 32'hABCD1234) begin n_errors++; $display("FAIL single_data got %h want ABCD1234", sdr_data); end
    @(negedge clk);
    n_checks += 2;
    if (sdr_rdy !== 1'b0) begin n_errors++; $display("FAIL single_rdy_width got %b want 0", sdr_rdy); end
    if (sdr_data !== 32'hABCD1234) begin n_errors++; $display("FAIL single_data_hold got %h want ABCD1234", sdr_data); end
  endtask

  task automatic test_cache_repeat();
    int t0, t1;
    bit ok;
`ifdef GFX_ROM_CACHE_EN
    bit saw_req;
    int n_rdy;
    saw_req = 1'b0;
    n_rdy   = 0;
    t1      = -1;
    send_req(20'h00010, t0);
    for (int i = 0; i < 10; i++) begin
      if (mem_req) saw_req = 1'b1;
      if (sdr_rdy) begin
        n_rdy++;
        if (t1 < 0) t1 = cyc;
        n_checks++;
        if (sdr_data !== 32'hABCD1234) begin n_errors++; $display("FAIL hit_data got %h want ABCD1234", sdr_data); end
      end
      @(negedge clk);
    end
    n_checks += 3;
    if (saw_req) begin n_errors++; $display("FAIL hit_mem_req got 1 want 0"); end
    if (n_rdy != 1) begin n_errors++; $display("FAIL hit_rdy_count got %0d want 1", n_rdy); end
    if (t1 - t0 != 3) begin n_errors++; $display("FAIL hit_latency got %0d want 3", t1 - t0); end
`else
    bit stable;
    logic [24:0] a;
    logic ra;
    send_req(20'h00010, t0);
    mem_serve(0, 1'b0, 1'b0, 16'h5678, 16'h9ABC, a, stable, ra, ok);
    n_checks += 2;
    if (!ok) begin n_errors++; $display("FAIL repeat_mem_req got timeout want mem_req"); end
    if (a !== 25'h0100040) begin n_errors++; $display("FAIL repeat_mem_addr got %h want 0100040", a); end
    wait_rdy(t1, ok);
    n_checks += 2;
    if (!ok) begin n_errors++; $display("FAIL repeat_rdy got timeout want pulse"); end
    if (sdr_data !== 32'h9ABC5678) begin n_errors++; $display("FAIL repeat_data got %h want 9ABC5678", sdr_data); end
    @(negedge clk);
`endif
  endtask

  task automatic test_ack_with_beat();
    int t0, t1;
    bit ok, stable;
    logic [24:0] a;
    logic ra;
    send_req(20'h00030, t0);
    mem_serve(0, 1'b1, 1'b0, 16'h0F0F, 16'hF0F0, a, stable, ra, ok);
    n_checks += 2;
    if (!ok) begin n_errors++; $display("FAIL coincide_mem_req got timeout want mem_req"); end
    if (a !== 25'h01000C0) begin n_errors++; $display("FAIL coincide_mem_addr got %h want 01000C0", a); end
    wait_rdy(t1, ok);
    n_checks += 3;
    if (!ok) begin n_errors++; $display("FAIL coincide_rdy got timeout want pulse"); end
    if (t1 - t0 != 4) begin n_errors++; $display("FAIL coincide_latency got %0d want 4", t1 - t0); end
    if (sdr_data !== 32'hF0F00F0F) begin n_errors++; $display("FAIL coincide_data got %h want F0F00F0F", sdr_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    bit ok, stable, saw_req;
    logic [24:0] a;
    logic ra;
    logic [24:0] exp_addr [3];
    logic [15:0] d0s [3];
    logic [15:0] d1s [3];
    logic [31:0] exp_data [3];
    exp_addr = '{25'h0100100, 25'h0100004, 25'h0100008};
    d0s      = '{16'h4444, 16'h1111, 16'h2222};
    d1s      = '{16'h3333, 16'h0101, 16'h0202};
    exp_data = '{32'h33334444, 32'h01011111, 32'h02022222};
    // Primer occupies the FSM so the following three strobes meet the queue.
    send_req(20'h00040, t0);
    @(negedge clk); sdr_addr = 20'h00001; sdr_req = 1'b1;
    @(negedge clk); sdr_addr = 20'h00002;
    @(negedge clk); sdr_addr = 20'h00003;
    @(negedge clk); sdr_req  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mem_serve((k == 0) ? 10 : 0, 1'b0, (k == 0), d0s[k], d1s[k], a, stable, ra, ok);
      n_checks += 3;
      if (!ok) begin n_errors++; $display("FAIL b2b_mem_req_%0d got timeout want mem_req", k); end
      if (a !== exp_addr[k]) begin n_errors++; $display("FAIL b2b_mem_addr_%0d got %h want %h", k, a, exp_addr[k]); end
      if (!stable) begin n_errors++; $display("FAIL b2b_issue_stable_%0d got unstable want stable", k); end
      wait_rdy(t1, ok);
      n_checks += 2;
      if (!ok) begin n_errors++; $display("FAIL b2b_rdy_%0d got timeout want pulse", k); end
      if (sdr_data !== exp_data[k]) begin n_errors++; $display("FAIL b2b_data_%0d got %h want %h", k, sdr_data, exp_data[k]); end
      @(negedge clk);
    end
    saw_req = 1'b0;
    repeat (10) begin
      if (mem_req) saw_req = 1'b1;
      @(negedge clk);
    end
    n_checks += 3;
    if (saw_req) begin n_errors++; $display("FAIL b2b_dropped got mem_req want none"); end
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL b2b_overflow got %b want 1", overflow); end
    if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL b2b_idle got %0d want 0", dbg_state); end
  endtask

  task automatic test_reset_mid_fetch();
    int t0, t1;
    bit ok, stable, bad;
    logic [24:0] a;
    logic ra;
    send_req(20'h00020, t0);
    for (int i = 0; i < 60 && !mem_req; i++) @(negedge clk);
    n_checks++;
    if (!mem_req) begin n_errors++; $display("FAIL rstmid_mem_req got timeout want mem_req"); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_valid = 1'b1; mem_dout = 16'h5555;
    @(negedge clk);
    mem_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks += 5;
    if (mem_req !== 1'b0)   begin n_errors++; $display("FAIL rstmid_mem_req_low got %b want 0", mem_req); end
    if (sdr_rdy !== 1'b0)   begin n_errors++; $display("FAIL rstmid_rdy got %b want 0", sdr_rdy); end
    if (overflow !== 1'b0)  begin n_errors++; $display("FAIL rstmid_overflow got %b want 0", overflow); end
    if (sdr_data !== 32'h0) begin n_errors++; $display("FAIL rstmid_data got %h want 0", sdr_data); end
    if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL rstmid_state got %0d want 0", dbg_state); end
    mem_valid = 1'b1; mem_dout = 16'h7777;
    @(negedge clk);
    mem_valid = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      if (sdr_rdy || mem_req) bad = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (bad) begin n_errors++; $display("FAIL rstmid_late_beat got activity want none"); end
    send_req(20'h00005, t0);
    mem_serve(0, 1'b0, 1'b0, 16'hC0DE, 16'hBEEF, a, stable, ra, ok);
    n_checks += 2;
    if (!ok) begin n_errors++; $display("FAIL rstmid_next_req got timeout want mem_req"); end
    if (a !== 25'h0100014) begin n_errors++; $display("FAIL rstmid_next_addr got %h want 0100014", a); end
    wait_rdy(t1, ok);
    n_checks += 3;
    if (!ok) begin n_errors++; $display("FAIL rstmid_next_rdy got timeout want pulse"); end
    if (t1 - t0 != 5) begin n_errors++; $display("FAIL rstmid_next_latency got %0d want 5", t1 - t0); end
    if (sdr_data !== 32'hBEEFC0DE) begin n_errors++; $display("FAIL rstmid_next_data got %h want BEEFC0DE", sdr_data); end
    @(negedge clk);
  endtask

  task automatic test_addr_wrap();
    logic [19:0] addrs [2];
    logic [24:0] exp_a [2];
    bit got;
    addrs = '{20'h00008, 20'hFFFFF};
    exp_a = '{25'h0000010, 25'h03FFFEC};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); w_addr = addrs[k]; w_req = 1'b1;
      @(negedge clk); w_req = 1'b0;
      for (int i = 0; i < 60 && !w_mem_req; i++) @(negedge clk);
      n_checks += 2;
      if (!w_mem_req) begin n_errors++; $display("FAIL wrap_mem_req_%0d got timeout want mem_req", k); end
      if (w_mem_addr !== exp_a[k]) begin n_errors++; $display("FAIL wrap_mem_addr_%0d got %h want %h", k, w_mem_addr, exp_a[k]); end
      w_mem_ack = 1'b1;
      @(negedge clk); w_mem_ack = 1'b0; w_mem_valid = 1'b1; w_mem_dout = 16'h0001;
      @(negedge clk); w_mem_dout = 16'h0002;
      @(negedge clk); w_mem_valid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        if (w_rdy) got = 1'b1;
        else @(negedge clk);
      end
      n_checks += 2;
      if (!got) begin n_errors++; $display("FAIL wrap_rdy_%0d got timeout want pulse", k); end
      if (w_data !== 32'h00020001) begin n_errors++; $display("FAIL wrap_data_%0d got %h want 00020001", k, w_data); end
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_single_fetch();
    test_cache_repeat();
    test_ack_with_beat();
    test_back_to_back();
    test_reset_mid_fetch();
    test_addr_wrap();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gfx_rom_responder.md
Name: gfx_rom_responder

Overview:
- Serves 32-bit graphics-ROM fetches issued by a tile or sprite layer over the sdr_req/sdr_addr/sdr_data/sdr_rdy interface.
- Converts each request into a two-beat 16-bit burst on the SDRAM controller port.
- Assembles the beats and returns one 32-bit word with a single-cycle sdr_rdy pulse.
- Sits between one layer block and one SDRAM controller channel; a 2-entry request queue absorbs back-to-back requests.

Parameters:
- BASE_ADDR, 25'h0100000, byte address in SDRAM of ROM word 0.
- QDEPTH_LOG2, 1, log2 of request queue depth (default 2 entries).

Ports:
- CLK_32M  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- sdr_req  in  1  one-cycle request strobe from the layer.
- sdr_addr  in  20  32-bit word address, sampled when sdr_req=1.
- sdr_data  out  32  returned ROM word.
- sdr_rdy  out  1  one-cycle pulse; sdr_data is valid this cycle.
- mem_addr  out  25  SDRAM byte address of the burst.
- mem_req  out  1  burst request; held high until mem_ack.
- mem_ack  in  1  controller accepted the burst.
- mem_valid  in  1  16-bit beat valid.
- mem_dout  in  16  beat data.
- overflow  out  1  sticky flag: a request was dropped because the queue was full.

Behaviour:
- Reset: the following clear in the cycle RESET is sampled high.
  - Outputs: sdr_data=0, sdr_rdy=0, mem_req=0, mem_addr=0, overflow=0.
  - Queue emptied, FSM forced to IDLE.
- Reset mid-operation: pending beats are abandoned; mem_valid is ignored while in IDLE.
- Address arithmetic: mem_addr = BASE_ADDR + {sdr_addr, 2'b00}, computed in 25 bits; wraps modulo 2^25.
- Queue:
  - sdr_req with queue not full pushes sdr_addr.
  - sdr_req with queue full drops the request and sets overflow; overflow clears only on RESET.
  - Push and pop in the same cycle are both honoured.
- FSM states and transitions:
  - IDLE: if the queue is non-empty, pop the head, load mem_addr, assert mem_req, go to ISSUE.
  - ISSUE: hold mem_req and mem_addr stable. On mem_ack, drop mem_req the next cycle and go to BEAT0.
  - BEAT0: on mem_valid, capture mem_dout into data[15:0] and go to BEAT1.
  - BEAT1: on mem_valid, capture mem_dout into data[31:16] and go to RESP.
  - RESP: load sdr_data, pulse sdr_rdy for exactly one cycle, return to IDLE.
- mem_valid while in ISSUE (before mem_ack) is ignored.
- mem_ack and the first mem_valid may coincide. In that case the beat is captured as beat0 and the FSM goes directly to BEAT1.
- Latency, sdr_req to sdr_rdy with an empty queue: 2 cycles plus the controller's ack and beat delays. With ack and both beats on consecutive cycles, sdr_rdy occurs 5 cycles after sdr_req.
- sdr_data holds its value until the next sdr_rdy.
- sdr_rdy is never asserted on two consecutive cycles.
- Requests are answered strictly in order.

Optional Feature:
- Macro: GFX_ROM_CACHE_EN.
  - When defined: the last completed address/data pair is held in a 1-entry tag register. A popped address equal to that tag (tag valid) skips ISSUE/BEAT0/BEAT1: mem_req stays low and RESP follows IDLE directly, so a hit responds 3 cycles after sdr_req. The tag is invalidated by RESET.
  - When undefined: every request goes to memory; no tag logic is present.

Test Plan:
- Single fetch: sdr_addr=20'h00010 pulse; mem_ack one cycle after mem_req; beats 16'h1234 then 16'hABCD -> mem_addr=25'h0100040, sdr_data=32'hABCD1234, one sdr_rdy pulse.
- Back-to-back: requests 20'h00001, 20'h00002, 20'h00003 on consecutive cycles with the controller stalling ack 10 cycles -> first two are served in order, third is dropped, overflow=1.
- RESET asserted after beat0 of a fetch -> mem_req=0, no sdr_rdy, overflow=0. A late mem_valid is ignored; the next request 20'h00005 is answered correctly.
- Address wrap: BASE_ADDR=25'h1FFFFF0, sdr_addr=20'h00008 -> mem_addr=25'h0000010.
- mem_ack coinciding with the first mem_valid (16'h0F0F), then 16'hF0F0 -> sdr_data=32'hF0F00F0F.
- With GFX_ROM_CACHE_EN: repeat a request for 20'h00010 -> mem_req stays 0, sdr_rdy 3 cycles after sdr_req with the same data. Without the macro, mem_req is reasserted.
